logic_op_issuer: RTL and testbench
==================================

// Module: logic_op_issuer
// PURPOSE
//   Upstream issue stage for the 32-bit gate-level logic unit (AND/OR/XOR/ZERO via f0,f1).
//   Accepts operation requests over valid/ready and buffers one request. Drives registered
//   operands and select lines into the logic unit, then waits a fixed settle window for gate
//   propagation. Captures the unit's output into a result register with valid/ready back-pressure.
// PARAMETERS
//   DATA_W         32  operand/result width; matches the logic unit
//   SETTLE_CYCLES  4   clocks to wait after driving the unit before sampling lu_out; legal range >=1
// PORTS
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   in_valid   in   1       request valid
//   in_ready   out  1       request accepted when in_valid && in_ready
//   in_a       in   DATA_W  operand A
//   in_b       in   DATA_W  operand B
//   in_op      in   2       {f0,f1}: 00 ZERO, 01 AND, 10 OR, 11 XOR
//   lu_a       out  DATA_W  registered operand A to logic unit
//   lu_b       out  DATA_W  registered operand B to logic unit
//   lu_f0      out  1       select S0 to logic unit (= op[1])
//   lu_f1      out  1       select S1 to logic unit (= op[0])
//   lu_out     in   DATA_W  logic unit result
//   res_valid  out  1       result valid
//   res_ready  in   1       result consumed when res_valid && res_ready
//   res_data   out  DATA_W  captured result
//   res_op     out  2       op that produced res_data
// BEHAVIOUR
//   - Reset: pend_full=0, in_ready=1, lu_a/lu_b/lu_f0/lu_f1=0, res_valid=0, res_data=0, res_op=0,
//     cnt=0, state=IDLE. Reset mid-operation discards pending, in-flight and held results.
//   - Pending buffer: 1 entry. in_ready = !pend_full, combinational from the register only.
//     Accept sets pend_full and stores {a,b,op}.
//   - FSM states: IDLE, SETTLE, WAIT.
//   - IDLE: if pend_full, load lu_* from pending, clear pend_full, set cnt=SETTLE_CYCLES-1,
//     go to SETTLE. Accept and issue do not bypass: a request enters lu_* at the earliest one
//     edge after acceptance.
//   - SETTLE: if cnt!=0, decrement cnt. If cnt==0 and slot_free, capture lu_out into res_data
//     and lu op into res_op, set res_valid=1, go to IDLE. If cnt==0 and !slot_free, go to WAIT.
//   - slot_free = !res_valid || res_ready.
//   - WAIT: lu_* stay held. When slot_free, capture as above and go to IDLE.
//   - Capture while the old result is consumed on the same edge is allowed: res_valid stays 1
//     with the new data, no bubble.
//   - res_valid clears on res_ready only if no capture happens on that edge.
//   - res_data/res_op are stable while res_valid && !res_ready.
//   - lu_* change only on issue; they are held through SETTLE and WAIT and after capture.
//   - Latency accept->res_valid = SETTLE_CYCLES+1 clocks. Sustained throughput = 1 op per
//     SETTLE_CYCLES+1 clocks.
//   - The pending buffer refills during SETTLE/WAIT. While it is full and the FSM is busy,
//     in_ready=0.
//   - Op 00 (ZERO) takes the full path. No shortcut; the captured result is whatever lu_out
//     reports (0).
// CONFIGURATION
//   LOGIC_ISSUE_FLAGS_EN defined: adds out ports res_zero (1) = (captured data == 0) and
//     res_parity (1) = ^captured data. Both are registered on the capture edge together with
//     res_data and reset to 0.
//   LOGIC_ISSUE_FLAGS_EN undefined: these ports and their registers do not exist.
// TESTING (SETTLE_CYCLES=4; edge 0 = accept edge; bench models the logic unit)
//   1. Single AND: A=30, B=40, op=01 at edge 0 -> lu_f0=0, lu_f1=1 after edge 1;
//      res_valid=1 with res_data=8, res_op=01 after edge 5.
//   2. Back-to-back, res_ready=1: OR then XOR on 30/40 -> res_data 62 then 54;
//      second res_valid 5 clocks after first. in_ready=0 while pending is full.
//   3. Backpressure: res_ready=0 holding 62, XOR settles -> FSM in WAIT, lu_* held.
//      res_ready=1 for one clock -> 54 replaces 62 on that edge, res_valid stays 1.
//   4. ZERO op: A=30, B=40, op=00 -> res_data=0. With LOGIC_ISSUE_FLAGS_EN: res_zero=1,
//      res_parity=0. AND result 8 gives res_zero=0, res_parity=1.
//   5. Reset mid-SETTLE (rst_n low at edge 3 of test 1) -> immediately res_valid=0,
//      in_ready=1, lu_*=0. No result ever appears for that request.
//   6. Third request while one is in flight and one is pending -> in_ready=0.
//      in_valid held; request accepted on the edge after the FSM issues the pending entry.

Source files
------------

// File: rtl/logic_op_issuer.sv
// Issue stage for the 32-bit gate-level logic unit: one-entry request buffer, fixed settle window,
// result register with back-pressure. Define LOGIC_ISSUE_FLAGS_EN to add res_zero/res_parity outputs.
module logic_op_issuer #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_op,
  output logic [DATA_W-1:0] lu_a,
  output logic [DATA_W-1:0] lu_b,
  output logic              lu_f0,
  output logic              lu_f1,
  input  logic [DATA_W-1:0] lu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_op
`ifdef LOGIC_ISSUE_FLAGS_EN
  ,
  output logic              res_zero,
  output logic              res_parity
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_full_q, pend_full_d;
  logic [DATA_W-1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [1:0]        pend_op_q, pend_op_d;
  logic [DATA_W-1:0] lu_a_q, lu_a_d, lu_b_q, lu_b_d;
  logic [1:0]        lu_op_q, lu_op_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [1:0]        res_op_q, res_op_d;
  logic              res_zero_q, res_zero_d;
  logic              res_parity_q, res_parity_d;

  logic accept, issue, capture, slot_free;

  assign in_ready  = !pend_full_q;
  assign accept    = in_valid && !pend_full_q;
  assign issue     = (state_q == IDLE) && pend_full_q;
  assign slot_free = !res_valid_q || res_ready;
  assign capture   = slot_free &&
                     (((state_q == SETTLE) && (cnt_q == '0)) || (state_q == WAIT));

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_full_d  = pend_full_q;
    pend_a_d     = pend_a_q;
    pend_b_d     = pend_b_q;
    pend_op_d    = pend_op_q;
    lu_a_d       = lu_a_q;
    lu_b_d       = lu_b_q;
    lu_op_d      = lu_op_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_op_d     = res_op_q;
    res_zero_d   = res_zero_q;
    res_parity_d = res_parity_q;

    // Accept only when empty and issue only when full, so the two never coincide.
    if (accept) begin
      pend_full_d = 1'b1;
      pend_a_d    = in_a;
      pend_b_d    = in_b;
      pend_op_d   = in_op;
    end

    case (state_q)
      IDLE: begin
        if (issue) begin
          pend_full_d = 1'b0;
          lu_a_d      = pend_a_q;
          lu_b_d      = pend_b_q;
          lu_op_d     = pend_op_q;
          cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0)       cnt_d   = cnt_q - 1'b1;
        else if (capture)      state_d = IDLE;
        else                   state_d = WAIT;
      end
      WAIT: begin
        if (capture) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A capture takes priority over consumption so a same-edge handoff leaves no bubble.
    if (capture) begin
      res_valid_d  = 1'b1;
      res_data_d   = lu_out;
      res_op_d     = lu_op_q;
      res_zero_d   = (lu_out == '0);
      res_parity_d = ^lu_out;
    end else if (res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_full_q  <= 1'b0;
      pend_a_q     <= '0;
      pend_b_q     <= '0;
      pend_op_q    <= '0;
      lu_a_q       <= '0;
      lu_b_q       <= '0;
      lu_op_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_op_q     <= '0;
      res_zero_q   <= 1'b0;
      res_parity_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_full_q  <= pend_full_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      pend_op_q    <= pend_op_d;
      lu_a_q       <= lu_a_d;
      lu_b_q       <= lu_b_d;
      lu_op_q      <= lu_op_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_op_q     <= res_op_d;
      res_zero_q   <= res_zero_d;
      res_parity_q <= res_parity_d;
    end
  end

  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_f0     = lu_op_q[1];
  assign lu_f1     = lu_op_q[0];
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;

`ifdef LOGIC_ISSUE_FLAGS_EN
  assign res_zero   = res_zero_q;
  assign res_parity = res_parity_q;
`else
  logic unused_flags;
  assign unused_flags = res_zero_q ^ res_parity_q;
`endif

endmodule

// File: tb/tb_logic_op_issuer.sv
// Directed bench for logic_op_issuer with SETTLE_CYCLES=4; the bench itself models the logic unit.
module tb_logic_op_issuer;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] lu_a, lu_b, lu_out;
  logic              lu_f0, lu_f1;
  logic              res_valid, res_ready;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        res_op;
`ifdef LOGIC_ISSUE_FLAGS_EN
  logic              res_zero, res_parity;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Logic unit model: {f0,f1} 00 ZERO, 01 AND, 10 OR, 11 XOR.
  always_comb begin
    case ({lu_f0, lu_f1})
      2'b01:   lu_out = lu_a & lu_b;
      2'b10:   lu_out = lu_a | lu_b;
      2'b11:   lu_out = lu_a ^ lu_b;
      default: lu_out = '0;
    endcase
  end

  logic_op_issuer #(.DATA_W(DATA_W), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_f0(lu_f0), .lu_f1(lu_f1), .lu_out(lu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op)
`ifdef LOGIC_ISSUE_FLAGS_EN
    , .res_zero(res_zero), .res_parity(res_parity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op);
    in_valid = 1'b1;
    in_a     = 32'd30;
    in_b     = 32'd40;
    in_op    = op;
  endtask

  logic saw_valid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; res_ready = 1'b1;
    step(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_lu_a", lu_a, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    step(1);

    // 1: single AND
    send(2'b01);
    step(1);                               // edge 0
    in_valid = 1'b0;
    check("t1_in_ready_full", in_ready, 0);
    check("t1_lu_f1_before_issue", lu_f1, 0);
    step(1);                               // edge 1
    check("t1_lu_f0", lu_f0, 0);
    check("t1_lu_f1", lu_f1, 1);
    check("t1_lu_a", lu_a, 30);
    check("t1_in_ready_free", in_ready, 1);
    step(3);                               // edge 4
    check("t1_valid_early", res_valid, 0);
    step(1);                               // edge 5
    check("t1_valid", res_valid, 1);
    check("t1_data", res_data, 8);
    check("t1_op", res_op, 1);
`ifdef LOGIC_ISSUE_FLAGS_EN
    check("t1_zero", res_zero, 0);
    check("t1_parity", res_parity, 1);
`endif
    step(1);
    check("t1_consumed", res_valid, 0);

    // 2: back-to-back OR then XOR
    send(2'b10);
    step(1);                               // edge 0
    send(2'b11);
    check("t2_in_ready_full", in_ready, 0);
    step(1);                               // edge 1: OR issued, XOR not yet taken
    check("t2_in_ready_after_issue", in_ready, 1);
    step(1);                               // edge 2: XOR accepted
    in_valid = 1'b0;
    check("t2_in_ready_refilled", in_ready, 0);
    step(3);                               // edge 5
    check("t2_first_valid", res_valid, 1);
    check("t2_first_data", res_data, 62);
    step(4);                               // edge 9
    check("t2_gap", res_valid, 0);
    step(1);                               // edge 10
    check("t2_second_valid", res_valid, 1);
    check("t2_second_data", res_data, 54);
    check("t2_second_op", res_op, 3);
    step(1);

    // 3: backpressure with WAIT
    res_ready = 1'b0;
    send(2'b10);
    step(1);
    send(2'b11);
    step(2);                               // edge 2
    in_valid = 1'b0;
    step(3);                               // edge 5
    check("t3_first", res_data, 62);
    step(7);                               // edge 12: XOR settled, FSM waiting
    check("t3_held_data", res_data, 62);
    check("t3_held_valid", res_valid, 1);
    check("t3_lu_f0_held", lu_f0, 1);
    check("t3_lu_f1_held", lu_f1, 1);
    check("t3_lu_b_held", lu_b, 40);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    check("t3_swap_valid", res_valid, 1);
    check("t3_swap_data", res_data, 54);
    step(1);
    check("t3_stable", res_data, 54);
    res_ready = 1'b1;
    step(1);
    check("t3_drained", res_valid, 0);

    // 4: ZERO op
    send(2'b00);
    step(1);
    in_valid = 1'b0;
    step(5);
    check("t4_valid", res_valid, 1);
    check("t4_data", res_data, 0);
    check("t4_op", res_op, 0);
`ifdef LOGIC_ISSUE_FLAGS_EN
    check("t4_zero", res_zero, 1);
    check("t4_parity", res_parity, 0);
`endif
    step(1);

    // 5: reset mid-SETTLE
    send(2'b01);
    step(1);                               // edge 0
    in_valid = 1'b0;
    step(2);                               // edge 2
    rst_n = 1'b0;
    #1;
    check("t5_valid", res_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_lu_a", lu_a, 0);
    check("t5_lu_f1", lu_f1, 0);
    step(1);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (res_valid) saw_valid = 1'b1;
    end
    check("t5_no_result", saw_valid, 0);

    // 6: third request while one in flight and one pending
    send(2'b01);
    step(1);                               // edge 0
    send(2'b10);
    step(2);                               // edge 2: OR pending, AND in flight
    send(2'b11);
    check("t6_in_ready_busy", in_ready, 0);
    step(3);                               // edge 5
    check("t6_and_done", res_data, 8);
    check("t6_still_blocked", in_ready, 0);
    step(1);                               // edge 6: OR issued
    check("t6_or_issued", lu_f0, 1);
    check("t6_in_ready_open", in_ready, 1);
    step(1);                               // edge 7: XOR accepted
    in_valid = 1'b0;
    check("t6_xor_taken", in_ready, 0);
    step(3);                               // edge 10
    check("t6_or_data", res_data, 62);
    step(5);                               // edge 15
    check("t6_xor_valid", res_valid, 1);
    check("t6_xor_data", res_data, 54);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
